// File: rtl/uba_page_xlate_if.sv
// Device-side translation handshake between the UBA device arbiter (master)
// and the page translator (slave).
interface uba_page_xlate_if;
    logic        devREQI;
    logic        devIOI;
    logic [0:35] pageADDRI;
    logic        devACKO;
    logic        xlateVALID;
    logic [0:35] busADDRO;
    logic [0:3]  pageFLAGS;
    logic        pageFAIL;
    logic [0:1]  failCODE;

    modport master (
        output devREQI, devIOI, pageADDRI,
        input  devACKO, xlateVALID, busADDRO, pageFLAGS, pageFAIL, failCODE
    );

    modport slave (
        input  devREQI, devIOI, pageADDRI,
        output devACKO, xlateVALID, busADDRO, pageFLAGS, pageFAIL, failCODE
    );
endinterface

// File: rtl/uba_page_xlate.sv
// Registered UBA page translator: device virtual page -> KS10 physical page
// through a page RAM, with hardware valid-clear sweep and fail reporting.
module uba_page_xlate #(
    parameter int PAGES = 64,
    parameter int PPNW  = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clrALL,
    input  logic            pageWRITE,
    input  logic            pageREAD,
    input  logic [0:35]     busADDRI,
    input  logic [0:35]     busDATAI,
    output logic [0:35]     pageDATAO,
    output logic            pageBUSY,
    output logic [0:7]      failCNT,
    input  logic            failCLR,
    uba_page_xlate_if.slave dev
);
    localparam int VPW   = $clog2(PAGES);
    localparam int WORDW = 15 - VPW;
    localparam int ENTW  = 4 + PPNW;
    localparam int HIW   = 36 - PPNW - WORDW;

    typedef enum logic [1:0] {SWEEP, IDLE, RESULT} state_t;

    state_t          state, state_nxt;
    logic [VPW-1:0]  idx;
    logic [0:ENTW-1] ram [PAGES];

    logic            ram_we;
    logic [VPW-1:0]  ram_wa;
    logic [0:ENTW-1] ram_wd;
    logic            accept;

    logic [VPW-1:0]  bidx, vpage;
    logic [0:ENTW-1] wentry, xent, rent;
    logic [0:1]      x_code;
    logic [0:35]     x_addr, rd_fmt;

    logic            res_valid, res_fail;
    logic [0:35]     res_addr;
    logic [0:3]      res_flags;
    logic [0:1]      res_code;
    logic            unused_bits;

    assign bidx   = busADDRI[36-VPW:35];
    assign vpage  = dev.pageADDRI[19:18+VPW];
    assign wentry = {busDATAI[18:21], busDATAI[36-PPNW:35]};
    assign rent   = ram[bidx];

    assign unused_bits = ^{busADDRI, busDATAI, dev.pageADDRI};

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SWEEP;
        else      state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            SWEEP:   if (!clrALL && idx == '1) state_nxt = IDLE;
            IDLE:    if (clrALL) state_nxt = SWEEP;
                     else if (dev.devREQI) state_nxt = RESULT;
            RESULT:  state_nxt = clrALL ? SWEEP : IDLE;
            default: state_nxt = SWEEP;
        endcase
    end

    // FSM: outputs and page RAM write port (sweep owns the port while busy)
    always_comb begin
        pageBUSY = (state == SWEEP);
        accept   = (state == IDLE) && dev.devREQI && !clrALL;
        ram_we   = 1'b0;
        ram_wa   = bidx;
        ram_wd   = wentry;
        if (state == SWEEP) begin
            ram_we = 1'b1;
            ram_wa = idx;
            ram_wd = '0;
        end else if (pageWRITE) begin
            ram_we = 1'b1;
        end
    end

    assign dev.devACKO = accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             idx <= '0;
        else if (clrALL)      idx <= '0;
        else if (pageBUSY)    idx <= idx + VPW'(1);
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_wa] <= ram_wd;
    end

    // A KS10 write to the page being translated in the accept cycle wins.
    always_comb begin
        xent = ram[vpage];
        if (!pageBUSY && pageWRITE && (bidx == vpage)) xent = wentry;
    end

    always_comb begin
        x_code = 2'd0;
        if (!dev.devIOI) begin
            if (dev.pageADDRI[18])                               x_code = 2'd1;
            else if (xent[2] && (dev.pageADDRI[34] || dev.pageADDRI[35])) x_code = 2'd2;
            else if (!xent[3])                                   x_code = 2'd3;
        end
        x_addr = {dev.pageADDRI[0:HIW-1], xent[4:ENTW-1], dev.pageADDRI[34-WORDW:33]};
    end

    always_comb begin
        rd_fmt              = '0;
        rd_fmt[5:8]         = rent[0:3];
        rd_fmt[27-PPNW:26]  = rent[4:ENTW-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            res_fail  <= 1'b0;
            res_addr  <= '0;
            res_flags <= '0;
            res_code  <= '0;
        end else begin
            res_valid <= accept;
            if (accept) begin
                res_addr  <= x_addr;
                res_flags <= xent[0:3];
                res_code  <= x_code;
                res_fail  <= (x_code != 2'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                        failCNT <= '0;
        else if (failCLR)                                failCNT <= '0;
        else if (res_valid && res_fail && failCNT != '1) failCNT <= failCNT + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       pageDATAO <= '0;
        else if (pageREAD && !pageBUSY) pageDATAO <= rd_fmt;
    end

    assign dev.xlateVALID = res_valid;
    assign dev.busADDRO   = res_addr;
    assign dev.pageFLAGS  = res_flags;
    assign dev.pageFAIL   = res_fail;
    assign dev.failCODE   = res_code;
endmodule

// File: tb/tb_uba_page_xlate.sv
// Directed, table-driven bench for uba_page_xlate (PAGES=64, PPNW=11).
module tb_uba_page_xlate;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clrALL = 1'b0, pageWRITE = 1'b0, pageREAD = 1'b0, failCLR = 1'b0;
    logic [0:35] busADDRI = '0, busDATAI = '0;
    logic [0:35] pageDATAO;
    logic        pageBUSY;
    logic [0:7]  failCNT;

    uba_page_xlate_if dif();

    uba_page_xlate #(.PAGES(64), .PPNW(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .clrALL    (clrALL),
        .pageWRITE (pageWRITE),
        .pageREAD  (pageREAD),
        .busADDRI  (busADDRI),
        .busDATAI  (busDATAI),
        .pageDATAO (pageDATAO),
        .pageBUSY  (pageBUSY),
        .failCNT   (failCNT),
        .failCLR   (failCLR),
        .dev       (dif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        io;
        logic [0:35] addr;
        logic [0:35] exp_addr;
        logic [0:3]  exp_flags;
        logic        exp_fail;
        logic [0:1]  exp_code;
    } vec_t;

    vec_t vecs [13];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [0:35] act, input logic [0:35] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %o expected %o", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [0:35] a, input logic [0:35] d);
        busADDRI = a; busDATAI = d; pageWRITE = 1'b1;
        tick();
        pageWRITE = 1'b0;
    endtask

    task automatic rd(input logic [0:35] a);
        busADDRI = a; pageREAD = 1'b1;
        tick();
        pageREAD = 1'b0;
    endtask

    // Returns in the RESULT cycle (one clock after the accept edge).
    task automatic do_xlate(input logic io, input logic [0:35] addr);
        int n;
        dif.devIOI = io; dif.pageADDRI = addr; dif.devREQI = 1'b1;
        #1;
        n = 0;
        while (!dif.devACKO && n < 20) begin
            tick(); #1; n++;
        end
        if (!dif.devACKO) begin
            checks++; errors++;
            $display("FAIL ack_timeout: devACKO stayed 0 for addr %o", addr);
        end
        tick();
        dif.devREQI = 1'b0;
        chk("xlateVALID", 36'(dif.xlateVALID), 36'd1);
    endtask

    task automatic chk_res(input string tag, input logic [0:35] ea, input logic [0:3] ef,
                           input logic efail, input logic [0:1] ecode);
        chk({tag, "_addr"},  dif.busADDRO, ea);
        chk({tag, "_flags"}, 36'(dif.pageFLAGS), 36'(ef));
        chk({tag, "_fail"},  36'(dif.pageFAIL), 36'(efail));
        chk({tag, "_code"},  36'(dif.failCODE), 36'(ecode));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, acks, vcnt, exp_fcnt;

        vecs[0]  = '{1'b0, 36'o000000_027760, 36'o000000_123774, 4'b0001, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 36'o123456_024007, 36'o123454_123001, 4'b0001, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 36'o000000_044401, 36'o000000_777100, 4'b0011, 1'b1, 2'd2};
        vecs[3]  = '{1'b0, 36'o000000_044402, 36'o000000_777100, 4'b0011, 1'b1, 2'd2};
        vecs[4]  = '{1'b0, 36'o000000_044400, 36'o000000_777100, 4'b0011, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 36'o000000_444401, 36'o000000_777100, 4'b0011, 1'b1, 2'd1};
        vecs[6]  = '{1'b1, 36'o000000_444401, 36'o000000_777100, 4'b0011, 1'b0, 2'd0};
        vecs[7]  = '{1'b1, 36'o000000_044401, 36'o000000_777100, 4'b0011, 1'b0, 2'd0};
        vecs[8]  = '{1'b0, 36'o000000_063774, 36'o000001_234777, 4'b1101, 1'b0, 2'd0};
        vecs[9]  = '{1'b0, 36'o000000_014050, 36'o000000_000012, 4'b0000, 1'b1, 2'd3};
        vecs[10] = '{1'b0, 36'o000000_414050, 36'o000000_000012, 4'b0000, 1'b1, 2'd1};
        vecs[11] = '{1'b1, 36'o000000_374000, 36'o000000_000000, 4'b0000, 1'b0, 2'd0};
        vecs[12] = '{1'b0, 36'o000000_014051, 36'o000000_000012, 4'b0000, 1'b1, 2'd3};

        dif.devREQI = 1'b0; dif.devIOI = 1'b0; dif.pageADDRI = 36'o000000_024000;

        // T1: reset state, then sweep length with a request held throughout
        #2 rst = 1'b0;
        dif.devREQI = 1'b1;
        #1;
        chk("rst_busy",   36'(pageBUSY), 36'd1);
        chk("rst_ack",    36'(dif.devACKO), 36'd0);
        chk("rst_valid",  36'(dif.xlateVALID), 36'd0);
        chk_res("rst", '0, 4'b0000, 1'b0, 2'd0);
        chk("rst_fcnt",   36'(failCNT), 36'd0);
        chk("rst_dataout", pageDATAO, '0);
        tick(); tick();
        rst = 1'b1;
        #1;
        n = 0; acks = 0;
        while (pageBUSY && n < 200) begin
            if (dif.devACKO) acks++;
            tick(); #1; n++;
        end
        chk("sweep_cycles", 36'(n), 36'd64);
        chk("sweep_noack",  36'(acks), 36'd0);
        do_xlate(1'b0, 36'o000000_024000);
        chk_res("t1", '0, 4'b0000, 1'b1, 2'd3);
        tick();
        chk("valid_pulse", 36'(dif.xlateVALID), 36'd0);
        chk("result_held", 36'(dif.failCODE), 36'd3);
        exp_fcnt = 1;

        // T2/T3: populate entries (with junk in ignored bits), then the vector table
        wr(36'o777777_777705, 36'o000000_040123);
        wr(36'o123456_765411, 36'o777777_174777);
        wr(36'o000000_000014, 36'o000000_641234);
        for (int i = 0; i < 13; i++) begin
            do_xlate(vecs[i].io, vecs[i].addr);
            chk_res($sformatf("v%0d", i), vecs[i].exp_addr, vecs[i].exp_flags,
                    vecs[i].exp_fail, vecs[i].exp_code);
            if (vecs[i].exp_fail) exp_fcnt++;
        end
        tick();
        chk("fcnt_table", 36'(failCNT), 36'(exp_fcnt));

        // T4: write/translate bypass on the same page, then reads
        busADDRI = 36'o000000_000007; busDATAI = 36'o000000_040004; pageWRITE = 1'b1;
        dif.devIOI = 1'b0; dif.pageADDRI = 36'o000000_034000; dif.devREQI = 1'b1;
        #1;
        chk("bypass_ack", 36'(dif.devACKO), 36'd1);
        tick();
        pageWRITE = 1'b0; dif.devREQI = 1'b0;
        chk("bypass_valid", 36'(dif.xlateVALID), 36'd1);
        chk_res("bypass", 36'o000000_004000, 4'b0001, 1'b0, 2'd0);
        tick();
        rd(36'o000000_000007);
        chk("read7", pageDATAO, 36'o001000_004000);
        busDATAI = 36'o000000_040005; pageWRITE = 1'b1;
        rd(36'o000000_000007);
        pageWRITE = 1'b0;
        chk("read_old_on_rw", pageDATAO, 36'o001000_004000);
        tick();
        chk("read_held", pageDATAO, 36'o001000_004000);
        rd(36'o000000_000007);
        chk("read7_new", pageDATAO, 36'o001000_005000);
        rd(36'o000000_000014);
        chk("read12", pageDATAO, 36'o015001_234000);

        // T5: fail counter saturation and clear priority
        failCLR = 1'b1; tick(); failCLR = 1'b0;
        chk("fcnt_clr", 36'(failCNT), 36'd0);
        for (int i = 0; i < 254; i++) do_xlate(1'b0, 36'o000000_014050);
        tick();
        chk("fcnt_254", 36'(failCNT), 36'd254);
        for (int i = 0; i < 46; i++) do_xlate(1'b0, 36'o000000_014050);
        tick();
        chk("fcnt_sat", 36'(failCNT), 36'd255);
        do_xlate(1'b0, 36'o000000_014050);
        failCLR = 1'b1; tick(); failCLR = 1'b0;
        chk("fcnt_clr_wins", 36'(failCNT), 36'd0);

        // T6: clrALL while a result is pending
        dif.devIOI = 1'b0; dif.pageADDRI = 36'o000000_027760; dif.devREQI = 1'b1;
        #1;
        chk("pre_clr_ack", 36'(dif.devACKO), 36'd1);
        tick();
        dif.devREQI = 1'b0; clrALL = 1'b1;
        #1;
        chk("clr_pending_valid", 36'(dif.xlateVALID), 36'd1);
        chk("clr_pending_addr", dif.busADDRO, 36'o000000_123774);
        tick();
        clrALL = 1'b0;
        chk("clr_busy", 36'(pageBUSY), 36'd1);
        chk("clr_valid_off", 36'(dif.xlateVALID), 36'd0);
        wr(36'o000000_000000, 36'o000000_040001);
        rd(36'o000000_000005);
        chk("sweep_read_ignored", pageDATAO, 36'o015001_234000);
        dif.devREQI = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            #1; if (dif.devACKO) acks++;
            tick();
        end
        dif.devREQI = 1'b0;
        chk("sweep2_noack", 36'(acks), 36'd0);
        clrALL = 1'b1; tick(); clrALL = 1'b0;
        #1;
        n = 0;
        while (pageBUSY && n < 200) begin
            tick(); #1; n++;
        end
        chk("restart_cycles", 36'(n), 36'd64);
        do_xlate(1'b0, 36'o000000_027760);
        chk_res("clr5", 36'o000000_000774, 4'b0000, 1'b1, 2'd3);
        do_xlate(1'b0, 36'o000000_044401);
        chk_res("clr9", 36'o000000_000100, 4'b0000, 1'b1, 2'd3);
        do_xlate(1'b0, 36'o000000_000000);
        chk_res("clr0", 36'o000000_000000, 4'b0000, 1'b1, 2'd3);
        do_xlate(1'b0, 36'o123456_024007);
        chk_res("pre_rst", 36'o123454_000001, 4'b0000, 1'b1, 2'd3);
        tick();

        // rst asserted in the accept cycle: the result never appears
        dif.pageADDRI = 36'o000000_024000; dif.devREQI = 1'b1;
        #1;
        chk("rst_case_ack", 36'(dif.devACKO), 36'd1);
        rst = 1'b0;
        #1;
        dif.devREQI = 1'b0;
        chk("rst2_valid", 36'(dif.xlateVALID), 36'd0);
        chk_res("rst2", '0, 4'b0000, 1'b0, 2'd0);
        chk("rst2_fcnt", 36'(failCNT), 36'd0);
        chk("rst2_busy", 36'(pageBUSY), 36'd1);
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (dif.xlateVALID) vcnt++;
            tick();
        end
        chk("rst2_no_pulse", 36'(vcnt), 36'd0);
        rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
